// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampled, majority-voted bits,
// 5-8 data bits, optional even/odd parity, one or two stop bits.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_MAX   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_i,
    input  logic                start_edge_i,
    input  logic                ov_tick_i,
    input  logic [1:0]          data_width_i,
    input  logic [1:0]          parity_mode_i,
    input  logic                stop_bits_i,
    output logic [DATA_MAX-1:0] data_o,
    output logic                data_valid_o,
    output logic                parity_error_o,
    output logic                frame_error_o,
    output logic                busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_MAX > 1) ? $clog2(DATA_MAX) : 1;

    localparam logic [CW-1:0] C_LO   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_HI   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          smp_q, smp_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DATA_MAX-1:0] shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                stop2_q, stop2_d;
    logic [1:0]          cfg_w_q, cfg_w_d;
    logic [1:0]          cfg_p_q, cfg_p_d;
    logic                cfg_s_q, cfg_s_d;
    logic [DATA_MAX-1:0] data_q, data_d;
    logic                perr_o_q, perr_o_d;
    logic                ferr_o_q, ferr_o_d;

    logic          tick;
    logic          decide;
    logic          wrap;
    logic          maj;
    logic          par_en;
    logic          ferr_now;
    logic [IW-1:0] last_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop2_q  <= 1'b0;
            cfg_w_q  <= '0;
            cfg_p_q  <= '0;
            cfg_s_q  <= 1'b0;
            data_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            stop2_q  <= stop2_d;
            cfg_w_q  <= cfg_w_d;
            cfg_p_q  <= cfg_p_d;
            cfg_s_q  <= cfg_s_d;
            data_q   <= data_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        smp_d    = smp_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        stop2_d  = stop2_q;
        cfg_w_d  = cfg_w_q;
        cfg_p_d  = cfg_p_q;
        cfg_s_d  = cfg_s_q;
        data_d   = data_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;

        // Ticks are ignored while idle and in the single DONE cycle
        tick     = ov_tick_i && (state_q != S_IDLE) && (state_q != S_DONE);
        decide   = tick && (cnt_q == C_HI);
        wrap     = tick && (cnt_q == C_LAST);
        maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_i) | (smp_q[1] & rx_i);
        par_en   = ^cfg_p_q;
        ferr_now = ferr_q | ~maj;
        last_idx = IW'(cfg_w_q) + IW'(4);

        if (tick) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LO)  smp_d[0] = rx_i;
            if (cnt_q == C_MID) smp_d[1] = rx_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_edge_i) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    cfg_w_d = data_width_i;
                    cfg_p_d = parity_mode_i;
                    cfg_s_d = stop_bits_i;
                    shreg_d = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    stop2_d = 1'b0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shreg_d[idx_q] = maj;
                    par_d          = par_q ^ maj;
                end
                if (wrap) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        state_d = par_en ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_PARITY: begin
                // Odd mode (2'b10) inverts the sense of the check
                if (decide) perr_d = par_q ^ maj ^ cfg_p_q[1];
                if (wrap) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_d = ferr_now;
                    if (cfg_s_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        cnt_d    = '0;
                        data_d   = shreg_q;
                        perr_o_d = perr_q;
                        ferr_o_d = ferr_now;
                    end
                end
                if (wrap) cnt_d = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign data_o         = data_q;
    assign data_valid_o   = (state_q == S_DONE);
    assign parity_error_o = perr_o_q;
    assign frame_error_o  = ferr_o_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven tick by
// tick, valid pulses are captured by a monitor and checked inline.
module tb_uart_rx_deserializer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       start_edge_i = 1'b0;
    logic       ov_tick_i = 1'b0;
    logic [1:0] data_width_i = 2'b11;
    logic [1:0] parity_mode_i = 2'b00;
    logic       stop_bits_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_error_o;
    logic       frame_error_o;
    logic       busy_o;

    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0;
    logic [7:0] v_data = '0;
    logic       v_perr = 1'b0;
    logic       v_ferr = 1'b0;

    uart_rx_deserializer #(.OVERSAMPLE(16), .DATA_MAX(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .start_edge_i   (start_edge_i),
        .ov_tick_i      (ov_tick_i),
        .data_width_i   (data_width_i),
        .parity_mode_i  (parity_mode_i),
        .stop_bits_i    (stop_bits_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .parity_error_o (parity_error_o),
        .frame_error_o  (frame_error_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (data_valid_o) begin
            vcnt   <= vcnt + 1;
            v_data <= data_o;
            v_perr <= parity_error_o;
            v_ferr <= frame_error_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i) ov_tick_i = 1'b1;
        @(negedge clk_i) ov_tick_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b, input int gpos);
        for (int i = 0; i < 16; i++) begin
            rx_i = (i == gpos) ? ~b : b;
            tick();
        end
        rx_i = b;
    endtask

    // Start edge, then scramble config to prove it was latched
    task automatic start_pulse();
        @(negedge clk_i);
        rx_i = 1'b0;
        start_edge_i = 1'b1;
        @(negedge clk_i);
        start_edge_i = 1'b0;
        data_width_i = data_width_i ^ 2'b11;
        parity_mode_i = parity_mode_i ^ 2'b01;
        stop_bits_i = ~stop_bits_i;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] w,
                              input logic [1:0] pm, input logic pbit,
                              input logic sb, input logic s1, input logic s2,
                              input int gbit, input int gpos);
        int n;
        n = int'(w) + 5;
        data_width_i = w;
        parity_mode_i = pm;
        stop_bits_i = sb;
        start_pulse();
        send_bit(1'b0, -1);
        for (int i = 0; i < n; i++) send_bit(d[i], (i == gbit) ? gpos : -1);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pbit, -1);
        send_bit(s1, -1);
        if (sb) send_bit(s2, -1);
        rx_i = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_valid", 32'(data_valid_o), 32'h0);
        chk("rst_perr", 32'(parity_error_o), 32'h0);
        chk("rst_ferr", 32'(frame_error_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // 8N1 0xA5
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        repeat (2) @(negedge clk_i);
        chk("8n1_cnt", 32'(vcnt), 32'd1);
        chk("8n1_data", 32'(v_data), 32'hA5);
        chk("8n1_perr", 32'(v_perr), 32'h0);
        chk("8n1_ferr", 32'(v_ferr), 32'h0);
        chk("8n1_busy", 32'(busy_o), 32'h0);

        // 7E1 0x41, parity bit correct then wrong
        send_frame(8'h41, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        repeat (2) @(negedge clk_i);
        chk("7e1_cnt", 32'(vcnt), 32'd2);
        chk("7e1_data", 32'(v_data), 32'h41);
        chk("7e1_perr", 32'(v_perr), 32'h0);
        send_frame(8'h41, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
        repeat (2) @(negedge clk_i);
        chk("7e1b_cnt", 32'(vcnt), 32'd3);
        chk("7e1b_data", 32'(v_data), 32'h41);
        chk("7e1b_perr", 32'(v_perr), 32'h1);
        chk("7e1b_ferr", 32'(v_ferr), 32'h0);

        // 5O2 0x1F, second stop bit low; check valid latency
        data_width_i = 2'b00;
        parity_mode_i = 2'b10;
        stop_bits_i = 1'b1;
        start_pulse();
        send_bit(1'b0, -1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        rx_i = 1'b0;
        repeat (9) tick();
        chk("5o2_early_cnt", 32'(vcnt), 32'd3);
        chk("5o2_early_busy", 32'(busy_o), 32'h1);
        tick();
        chk("5o2_cnt", 32'(vcnt), 32'd4);
        chk("5o2_data", 32'(v_data), 32'h1F);
        chk("5o2_perr", 32'(v_perr), 32'h0);
        chk("5o2_ferr", 32'(v_ferr), 32'h1);
        rx_i = 1'b1;
        repeat (6) tick();
        chk("5o2_hold_data", 32'(data_o), 32'h1F);
        chk("5o2_hold_ferr", 32'(frame_error_o), 32'h1);

        // False start: 3-tick low glitch
        data_width_i = 2'b11;
        parity_mode_i = 2'b00;
        stop_bits_i = 1'b0;
        start_pulse();
        repeat (3) tick();
        rx_i = 1'b1;
        repeat (6) tick();
        chk("fs_busy_pre", 32'(busy_o), 32'h1);
        tick();
        chk("fs_busy_post", 32'(busy_o), 32'h0);
        repeat (10) tick();
        chk("fs_cnt", 32'(vcnt), 32'd4);
        chk("fs_data_hold", 32'(data_o), 32'h1F);
        chk("fs_ferr_hold", 32'(frame_error_o), 32'h1);

        // Single-tick glitch at count 8 of data bit 3
        send_frame(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3, 8);
        repeat (2) @(negedge clk_i);
        chk("gl_cnt", 32'(vcnt), 32'd5);
        chk("gl_data", 32'(v_data), 32'h00);
        chk("gl_ferr", 32'(v_ferr), 32'h0);

        // Back-to-back frames
        send_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        chk("b2b1_cnt", 32'(vcnt), 32'd6);
        chk("b2b1_data", 32'(v_data), 32'h55);
        send_frame(8'hAA, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        chk("b2b2_cnt", 32'(vcnt), 32'd7);
        chk("b2b2_data", 32'(v_data), 32'hAA);

        // Reset mid-frame
        data_width_i = 2'b11;
        parity_mode_i = 2'b00;
        stop_bits_i = 1'b0;
        start_pulse();
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b1, -1);
        rx_i = 1'b0;
        repeat (5) tick();
        @(negedge clk_i) rst_i = 1'b1;
        @(negedge clk_i) rst_i = 1'b0;
        chk("mr_data", 32'(data_o), 32'h0);
        chk("mr_perr", 32'(parity_error_o), 32'h0);
        chk("mr_ferr", 32'(frame_error_o), 32'h0);
        chk("mr_busy", 32'(busy_o), 32'h0);
        repeat (120) tick();
        rx_i = 1'b1;
        repeat (20) tick();
        chk("mr_cnt", 32'(vcnt), 32'd7);
        chk("mr_valid", 32'(data_valid_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
